mac_sched: RTL and testbench
============================

// Module: mac_sched
// PURPOSE
//   Command sequencer for the perceptron MAC datapath. Decodes host command bytes from the UART
//   receiver and drives the rest of the datapath: the serial loader (weight/input bytes), the
//   bank->acc add/clear strobes, the 128-bit accumulator read-out mux select and UART transmit.
//   Sits between uart rx/tx and serial/acc/mux, one byte at a time, with a busy handshake on tx.
// PARAMETERS
//   NBYTES    16  accumulator bytes streamed by READ (acc width / 8)
//   SEL_W     4   width of mux select, 2**SEL_W >= NBYTES
//   BANK_LAT  4   cycles from ser_get pulse to valid bank output at acc input (>=1)
// PORTS
//   clk        in   1      clock, all logic on rising edge
//   rst        in   1      synchronous reset, active-high
//   rx_data    in   8      received host byte
//   rx_valid   in   1      1-cycle strobe, rx_data valid
//   tx_busy    in   1      uart transmitter busy
//   tx_start   out  1      1-cycle strobe, send byte currently selected by sel
//   sel        out  SEL_W  accumulator byte select to mux (0 = LS byte)
//   acc_add    out  1      1-cycle strobe, accumulate bank output
//   acc_clear  out  1      1-cycle strobe, zero accumulator
//   ser_data   out  8      byte to serial loader
//   ser_send   out  1      1-cycle strobe, ser_data valid
//   ser_get    out  1      1-cycle strobe, shift next operand into bank
//   busy       out  1      1 whenever state != IDLE
//   status     out  8      {err_op, err_ovr, 3'b0, state[2:0]} (sticky errors)
// BEHAVIOUR
//   Reset: all strobes 0, sel=0, ser_data=0, busy=0, status=0, state=IDLE, counters 0.
//   Reset mid-command aborts it immediately; no strobe is emitted in the reset cycle.
//   Opcodes (accepted only in IDLE, on rx_valid):
//     0x00 NOP    no action.
//     0x01 CLEAR  acc_clear=1 the cycle after decode; stay IDLE.
//     0x02 LOAD   -> LEN: next rx byte = N. N=0 -> IDLE. Else -> LOAD: each of the next N rx
//                 bytes is copied to ser_data with ser_send=1 one cycle after its rx_valid;
//                 after N-th byte -> IDLE.
//     0x03 RUN    -> LEN: next byte = K iterations. K=0 -> IDLE. Else per iteration:
//                 RUN_GET (ser_get=1, 1 cycle) -> RUN_WAIT (BANK_LAT cycles) -> RUN_ADD
//                 (acc_add=1, 1 cycle); after K-th add -> IDLE. Iteration = BANK_LAT+2 cycles.
//     0x04 READ   sel=0 -> RD_ISSUE. RD_ISSUE: when tx_busy=0, tx_start=1 (1 cycle) -> RD_ACK.
//                 RD_ACK: wait tx_busy=1 -> RD_WAIT. RD_WAIT: wait tx_busy=0; if sel==NBYTES-1
//                 -> IDLE with sel=0, else sel+1 -> RD_ISSUE. sel stable while a byte is sending.
//     other       err_op set, stay IDLE.
//   rx_valid in RUN_*/RD_* states: byte dropped, err_ovr set. Only reset clears err bits.
//   Strobes never overlap: at most one of tx_start/acc_add/acc_clear/ser_send/ser_get per cycle.
//   Counters 8-bit; N,K = 255 must complete exactly 255 transfers/iterations (no wrap to 0).
//   state encoding: IDLE=0 LEN=1 LOAD=2 RUN_GET=3 RUN_WAIT=4 RUN_ADD=5 RD_ISSUE=6 RD_ACK/WAIT=7.
// TESTING
//   Reset with rx_valid=1 rx_data=0x01 -> no acc_clear, status=0x00, busy=0.
//   0x02,0x03,0xA1,0xB2,0xC3 -> three ser_send pulses with ser_data A1,B2,C3, then busy=0.
//   0x03,0x02 (BANK_LAT=4) -> ser_get at t, acc_add at t+5, ser_get t+6, acc_add t+11, IDLE.
//   0x04 with uart model (busy 10 cycles after tx_start) -> 16 tx_start, sel 0..15 in order,
//     each tx_start only after tx_busy low; ends sel=0, busy=0.
//   0x7F -> status[7]=1; byte during READ -> status[6]=1, READ still sends all 16 bytes.
//   0x03,0xFF then rst at iteration 100 -> strobes stop same edge, state IDLE, status 0.

Source files
------------

// File: rtl/mac_sched.sv
// mac_sched: host command sequencer for the perceptron MAC datapath.
// Latency: acc_clear/ser_send one cycle after the rx byte; ser_get/acc_add/tx_start follow the state.
// Backpressure: tx_busy stalls READ per byte; rx bytes arriving during RUN/READ are dropped (err_ovr).
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high; also masks every strobe in its own cycle
//   rx_data_i    received host byte
//   rx_valid_i   1-cycle strobe qualifying rx_data_i
//   tx_busy_i    uart transmitter busy
//   tx_start_o   1-cycle strobe, transmit the accumulator byte picked by sel_o
//   sel_o        accumulator byte select (0 = least significant byte)
//   acc_add_o    1-cycle strobe, accumulate bank output
//   acc_clear_o  1-cycle strobe, zero accumulator
//   ser_data_o   operand byte for the serial loader
//   ser_send_o   1-cycle strobe, ser_data_o valid
//   ser_get_o    1-cycle strobe, shift next operand into the bank
//   busy_o       high whenever the sequencer is not idle
//   status_o     {err_op, err_ovr, 3'b0, state[2:0]}, error bits sticky until reset
module mac_sched #(
  parameter int NBYTES   = 16,
  parameter int SEL_W    = 4,
  parameter int BANK_LAT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  input  logic             tx_busy_i,
  output logic             tx_start_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             acc_add_o,
  output logic             acc_clear_o,
  output logic [7:0]       ser_data_o,
  output logic             ser_send_o,
  output logic             ser_get_o,
  output logic             busy_o,
  output logic [7:0]       status_o
);

  // Wait counter only has to hold BANK_LAT.
  localparam int WCW = (BANK_LAT < 2) ? 1 : $clog2(BANK_LAT + 1);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h02;
  localparam logic [7:0] OP_RUN   = 8'h03;
  localparam logic [7:0] OP_READ  = 8'h04;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NBYTES - 1);

  // RD_ACK and RD_WAIT both report state code 7 on status; they differ only in
  // bit 3, which is never exported, so status can just take state_q[2:0].
  typedef enum logic [3:0] {
    ST_IDLE     = 4'h0,
    ST_LEN      = 4'h1,
    ST_LOAD     = 4'h2,
    ST_RUN_GET  = 4'h3,
    ST_RUN_WAIT = 4'h4,
    ST_RUN_ADD  = 4'h5,
    ST_RD_ISSUE = 4'h6,
    ST_RD_ACK   = 4'h7,
    ST_RD_WAIT  = 4'hF
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;         // transfers / iterations still to go
  logic [WCW-1:0]   wcnt_q, wcnt_d;       // bank latency countdown
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             is_run_q, is_run_d;   // LEN byte belongs to RUN (1) or LOAD (0)
  logic [7:0]       ser_data_q, ser_data_d;
  logic             ser_send_q, ser_send_d;
  logic             acc_clear_q, acc_clear_d;
  logic             err_op_q, err_op_d;
  logic             err_ovr_q, err_ovr_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      wcnt_q      <= '0;
      sel_q       <= '0;
      is_run_q    <= 1'b0;
      ser_data_q  <= 8'd0;
      ser_send_q  <= 1'b0;
      acc_clear_q <= 1'b0;
      err_op_q    <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      sel_q       <= sel_d;
      is_run_q    <= is_run_d;
      ser_data_q  <= ser_data_d;
      ser_send_q  <= ser_send_d;
      acc_clear_q <= acc_clear_d;
      err_op_q    <= err_op_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    sel_d       = sel_q;
    is_run_d    = is_run_q;
    ser_data_d  = ser_data_q;
    ser_send_d  = 1'b0;
    acc_clear_d = 1'b0;
    err_op_d    = err_op_q;
    err_ovr_d   = err_ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i) begin
          case (rx_data_i)
            OP_NOP: ;
            OP_CLEAR: acc_clear_d = 1'b1;
            OP_LOAD: begin
              is_run_d = 1'b0;
              state_d  = ST_LEN;
            end
            OP_RUN: begin
              is_run_d = 1'b1;
              state_d  = ST_LEN;
            end
            OP_READ: begin
              sel_d   = '0;
              state_d = ST_RD_ISSUE;
            end
            default: err_op_d = 1'b1;
          endcase
        end
      end

      ST_LEN: begin
        if (rx_valid_i) begin
          if (rx_data_i == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = rx_data_i;
            state_d = is_run_q ? ST_RUN_GET : ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (rx_valid_i) begin
          ser_data_d = rx_data_i;
          ser_send_d = 1'b1;
          // Count down to 1 rather than 0 so a length of 255 never wraps.
          if (cnt_q == 8'd1) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      ST_RUN_GET: begin
        wcnt_d  = WCW'(BANK_LAT);
        state_d = ST_RUN_WAIT;
      end

      // Holds exactly BANK_LAT cycles: entered with BANK_LAT, leaves on 1.
      ST_RUN_WAIT: begin
        if (wcnt_q == WCW'(1)) begin
          state_d = ST_RUN_ADD;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end

      ST_RUN_ADD: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          state_d = ST_RUN_GET;
        end
      end

      ST_RD_ISSUE: begin
        if (!tx_busy_i) begin
          state_d = ST_RD_ACK;
        end
      end

      // Wait for the transmitter to pick the byte up before waiting for it to
      // finish, so sel cannot move while the byte is still going out.
      ST_RD_ACK: begin
        if (tx_busy_i) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (!tx_busy_i) begin
          if (sel_q == SEL_LAST) begin
            sel_d   = '0;
            state_d = ST_IDLE;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = ST_RD_ISSUE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Host bytes are not consumed while running or reading out.
    if (rx_valid_i) begin
      case (state_q)
        ST_RUN_GET, ST_RUN_WAIT, ST_RUN_ADD,
        ST_RD_ISSUE, ST_RD_ACK, ST_RD_WAIT: err_ovr_d = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Every strobe is masked by rst_i so an abort is clean in the very
  // cycle reset is raised, even though the registers only clear on the edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_start_o  = !rst_i && (state_q == ST_RD_ISSUE) && !tx_busy_i;
    ser_get_o   = !rst_i && (state_q == ST_RUN_GET);
    acc_add_o   = !rst_i && (state_q == ST_RUN_ADD);
    acc_clear_o = !rst_i && acc_clear_q;
    ser_send_o  = !rst_i && ser_send_q;
    sel_o       = sel_q;
    ser_data_o  = ser_data_q;
    busy_o      = (state_q != ST_IDLE);
    status_o    = {err_op_q, err_ovr_q, 3'b000, state_q[2:0]};
  end

endmodule

// File: tb/tb_mac_sched.sv
module tb_mac_sched;

  localparam int NBYTES   = 16;
  localparam int SEL_W    = 4;
  localparam int BANK_LAT = 4;
  localparam int ITER     = BANK_LAT + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             tx_busy;
  logic             tx_start;
  logic [SEL_W-1:0] sel;
  logic             acc_add, acc_clear, ser_send, ser_get, busy;
  logic [7:0]       ser_data, status;

  mac_sched #(.NBYTES(NBYTES), .SEL_W(SEL_W), .BANK_LAT(BANK_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_busy_i(tx_busy), .tx_start_o(tx_start), .sel_o(sel), .acc_add_o(acc_add),
    .acc_clear_o(acc_clear), .ser_data_o(ser_data), .ser_send_o(ser_send),
    .ser_get_o(ser_get), .busy_o(busy), .status_o(status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for 10 cycles following each tx_start.
  int bcnt = 0;
  always @(posedge clk) begin
    if (rst) bcnt <= 0;
    else if (tx_start) bcnt <= 10;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // Event monitor, sampled mid-cycle.
  int ser_d_q[$], ser_c_q[$], get_q[$], add_q[$], clr_q[$], tx_q[$];
  int ovl = 0, rst_strobe = 0, txbad = 0, ns;
  always @(negedge clk) begin
    ns = int'(tx_start) + int'(acc_add) + int'(acc_clear) + int'(ser_send) + int'(ser_get);
    if (ns > 1) ovl++;
    if (rst === 1'b1 && ns != 0) rst_strobe++;
    if (ser_send === 1'b1) begin ser_d_q.push_back(int'(ser_data)); ser_c_q.push_back(cyc); end
    if (ser_get === 1'b1) get_q.push_back(cyc);
    if (acc_add === 1'b1) add_q.push_back(cyc);
    if (acc_clear === 1'b1) clr_q.push_back(cyc);
    if (tx_start === 1'b1) begin tx_q.push_back(int'(sel)); if (tx_busy) txbad++; end
  end

  int ncmp = 0, nfail = 0;
  int expd[$], expc[$], exp2[$];

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int obs[$], input int exp[$]);
    chk({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++) chk(tag, obs[i], exp[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one byte for one cycle; rc is the cycle it is valid in.
  task automatic rx_byte(input logic [7:0] b, output int rc);
    rx_data = b; rx_valid = 1'b1; rc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k = 0;
    while (busy === 1'b1 && k < bound) begin idle(1); k++; end
    chk({tag, "_idle"}, int'(busy === 1'b0), 1);
  endtask

  task automatic clr_mon();
    ser_d_q.delete(); ser_c_q.delete(); get_q.delete(); add_q.delete();
    clr_q.delete(); tx_q.delete(); expd.delete(); expc.delete(); exp2.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);
  endtask

  // Expected RUN trace: first get the cycle after the K byte, one per iteration,
  // each add BANK_LAT+1 cycles after its get.
  task automatic run_exp(input int rc, input int k);
    expc.delete(); exp2.delete();
    for (int i = 0; i < k; i++) begin
      expc.push_back(rc + 1 + i * ITER);
      exp2.push_back(rc + 1 + i * ITER + BANK_LAT + 1);
    end
  endtask

  initial begin
    int rc, n, b, rrst;
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h01;
    idle(3);
    rst = 1'b0; rx_valid = 1'b0;
    idle(2);
    chk("rst_no_clear", clr_q.size(), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_ser_data", int'(ser_data), 0);
    chk("rst_strobe", rst_strobe, 0);

    // CLEAR
    clr_mon();
    rx_byte(8'h01, rc); idle(2);
    expc.push_back(rc + 1);
    chk_q("clear_cyc", clr_q, expc);
    chk("clear_busy", int'(busy), 0);

    // LOAD directed
    clr_mon();
    rx_byte(8'h02, rc);
    chk("len_status", int'(status), 'h01);
    chk("len_busy", int'(busy), 1);
    rx_byte(8'h03, rc);
    chk("load_status", int'(status), 'h02);
    foreach (expd[i]) ;
    rx_byte(8'hA1, rc); expc.push_back(rc + 1); idle(1);
    rx_byte(8'hB2, rc); expc.push_back(rc + 1); idle(2);
    rx_byte(8'hC3, rc); expc.push_back(rc + 1);
    idle(2);
    expd.push_back('hA1); expd.push_back('hB2); expd.push_back('hC3);
    chk_q("load_data", ser_d_q, expd);
    chk_q("load_cyc", ser_c_q, expc);
    chk("load_busy", int'(busy), 0);

    // Random LOADs
    for (int t = 0; t < 4; t++) begin
      clr_mon();
      n = $urandom_range(1, 20);
      rx_byte(8'h02, rc); idle($urandom_range(0, 2));
      rx_byte(8'(n), rc); idle($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        b = $urandom_range(0, 255);
        rx_byte(8'(b), rc);
        expd.push_back(b); expc.push_back(rc + 1);
        idle($urandom_range(0, 3));
      end
      idle(2);
      chk_q("rload_data", ser_d_q, expd);
      chk_q("rload_cyc", ser_c_q, expc);
      chk("rload_busy", int'(busy), 0);
    end

    // LOAD with N=0
    clr_mon();
    rx_byte(8'h02, rc); rx_byte(8'h00, rc); idle(3);
    chk("load0_busy", int'(busy), 0);
    chk("load0_sends", ser_d_q.size(), 0);

    // RUN directed, K=2
    clr_mon();
    rx_byte(8'h03, rc); rx_byte(8'h02, rc);
    wait_idle(200, "run2"); idle(2);
    run_exp(rc, 2);
    chk_q("run2_get", get_q, expc);
    chk_q("run2_add", add_q, exp2);

    // Random RUNs
    for (int t = 0; t < 3; t++) begin
      clr_mon();
      n = $urandom_range(1, 8);
      rx_byte(8'h03, rc); idle($urandom_range(0, 3));
      rx_byte(8'(n), rc);
      wait_idle(500, "rrun"); idle(2);
      run_exp(rc, n);
      chk_q("rrun_get", get_q, expc);
      chk_q("rrun_add", add_q, exp2);
    end

    // RUN with K=0
    clr_mon();
    rx_byte(8'h03, rc); rx_byte(8'h00, rc); idle(3);
    chk("run0_busy", int'(busy), 0);
    chk("run0_gets", get_q.size() + add_q.size(), 0);

    // READ
    clr_mon();
    rx_byte(8'h04, rc);
    wait_idle(2000, "read"); idle(2);
    for (int i = 0; i < NBYTES; i++) expc.push_back(i);
    chk_q("read_sel", tx_q, expc);
    chk("read_tx_while_busy", txbad, 0);
    chk("read_end_sel", int'(sel), 0);

    // Illegal opcodes
    rx_byte(8'h7F, rc); idle(2);
    chk("err_op", int'(status), 'h80);
    rx_byte(8'($urandom_range(5, 255)), rc); idle(2);
    chk("err_op_sticky", int'(status), 'h80);
    do_reset();
    chk("err_cleared", int'(status), 0);

    // Byte arriving during READ
    clr_mon();
    rx_byte(8'h04, rc); idle(30);
    rx_byte(8'h55, rc);
    wait_idle(2000, "read_ovr"); idle(2);
    for (int i = 0; i < NBYTES; i++) expc.push_back(i);
    chk_q("read_ovr_sel", tx_q, expc);
    chk("err_ovr", int'(status), 'h40);
    chk("read_ovr_nosend", ser_d_q.size(), 0);

    // RUN K=255 to completion
    do_reset(); clr_mon();
    rx_byte(8'h03, rc); rx_byte(8'hFF, rc);
    wait_idle(3000, "run255"); idle(2);
    run_exp(rc, 255);
    chk_q("run255_get", get_q, expc);
    chk_q("run255_add", add_q, exp2);

    // LOAD N=255 back to back
    clr_mon();
    rx_byte(8'h02, rc); rx_byte(8'hFF, rc);
    for (int i = 0; i < 255; i++) begin
      b = $urandom_range(0, 255);
      rx_byte(8'(b), rc); expd.push_back(b); expc.push_back(rc + 1);
    end
    idle(2);
    chk_q("load255_data", ser_d_q, expd);
    chk_q("load255_cyc", ser_c_q, expc);
    chk("load255_busy", int'(busy), 0);

    // Reset during iteration 100 of a 255-iteration RUN
    clr_mon();
    rx_byte(8'h03, rc); rx_byte(8'hFF, rc);
    begin
      int k = 0;
      while (get_q.size() < 100 && k < 1000) begin idle(1); k++; end
    end
    rst = 1'b1; rrst = cyc;
    idle(2); rst = 1'b0; idle(20);
    run_exp(rc, 100); exp2.delete();
    for (int i = 0; i < 99; i++) exp2.push_back(rc + 1 + i * ITER + BANK_LAT + 1);
    chk_q("abort_get", get_q, expc);
    chk_q("abort_add", add_q, exp2);
    chk("abort_rst_strobe", rst_strobe, 0);
    chk("abort_status", int'(status), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_last_get_before_rst", int'(get_q.size() > 0 && get_q[$] < rrst), 1);

    chk("no_overlap", ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
